// File: rtl/player_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : player_sequencer_if
//  Description : CSR bus and player control/status bundle for the player
//                sequencer. The master side is the CPU plus the player memory,
//                the slave side is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface player_sequencer_if;
    logic [1:0]  csr_address;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        irq;
    logic        play_reset_n;
    logic        play_done;

    modport master (
        output csr_address,
        output csr_write,
        output csr_writedata,
        output csr_read,
        output play_done,
        input  csr_readdata,
        input  irq,
        input  play_reset_n
    );

    modport slave (
        input  csr_address,
        input  csr_write,
        input  csr_writedata,
        input  csr_read,
        input  play_done,
        output csr_readdata,
        output irq,
        output play_reset_n
    );
endinterface
`default_nettype wire

// File: rtl/player_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : player_sequencer
//  Description : Sequences a player memory through repeated playbacks. Holds
//                the player in rewind between plays for a programmable gap,
//                counts completed plays and raises an irq when a finite run
//                of plays completes.
//  Revision    : 1.0  initial release
// ============================================================================
module player_sequencer #(
    parameter int COUNT_BITS = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    player_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] C_ADDR_CONTROL = 2'd0;
    localparam logic [1:0] C_ADDR_REPEAT  = 2'd1;
    localparam logic [1:0] C_ADDR_GAP     = 2'd2;
    localparam logic [1:0] C_ADDR_PLAYS   = 2'd3;

    state_t                r_state;
    state_t                w_state_next;

    logic [COUNT_BITS-1:0] r_repeat;
    logic [COUNT_BITS-1:0] r_gap;
    logic [COUNT_BITS-1:0] r_plays;
    logic [COUNT_BITS-1:0] r_gap_cnt;
    logic                  r_irq_enable;
    logic                  r_irq_pending;
    logic                  r_play_reset_n;
    logic [31:0]           r_csr_readdata;

    logic                  w_wr_control;
    logic                  w_wr_repeat;
    logic                  w_wr_gap;
    logic                  w_wr_plays;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_start_accept;
    logic                  w_done_evt;
    logic                  w_complete;
    logic                  w_busy;
    logic                  w_gap_last;
    logic [COUNT_BITS-1:0] w_plays_inc;
    logic [COUNT_BITS-1:0] w_gap_load;
    logic [31:0]           w_control_rd;
    logic                  w_unused_wdata;

    // ------------------------------------------------------------------
    // CSR write decode
    // ------------------------------------------------------------------
    assign w_wr_control = bus.csr_write && (bus.csr_address == C_ADDR_CONTROL);
    assign w_wr_repeat  = bus.csr_write && (bus.csr_address == C_ADDR_REPEAT);
    assign w_wr_gap     = bus.csr_write && (bus.csr_address == C_ADDR_GAP);
    assign w_wr_plays   = bus.csr_write && (bus.csr_address == C_ADDR_PLAYS);

    // Stop has priority over start when both bits are written together.
    assign w_start        = w_wr_control && bus.csr_writedata[0];
    assign w_stop         = w_wr_control && bus.csr_writedata[1];
    assign w_start_accept = w_start && !w_stop && (r_state == ST_IDLE);

    // Only the low COUNT_BITS of REPEAT/GAP writes and bits [2:0] of a
    // CONTROL write carry meaning; the rest of the bus is intentionally
    // dropped.
    assign w_unused_wdata = ^bus.csr_writedata;

    // ------------------------------------------------------------------
    // Play bookkeeping
    // ------------------------------------------------------------------
    assign w_busy      = (r_state != ST_IDLE);
    assign w_plays_inc = r_plays + COUNT_BITS'(1);

    // A done pulse only counts while playing; a stop in the same cycle
    // abandons the play, so it neither counts nor completes the run.
    assign w_done_evt  = (r_state == ST_PLAY) && bus.play_done && !w_stop;

    // REPEAT is compared live, so a mid-run rewrite takes effect here.
    assign w_complete  = w_done_evt && (r_repeat != '0) && (w_plays_inc == r_repeat);

    // A zero gap still rewinds the player for one cycle.
    assign w_gap_load  = (r_gap == '0) ? COUNT_BITS'(1) : r_gap;
    assign w_gap_last  = (r_gap_cnt == COUNT_BITS'(1));

    // Next-state logic for the play sequencer.
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_done_evt) begin
                        w_state_next = w_complete ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_gap_last) begin
                        w_state_next = ST_PLAY;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Player rewind line, registered so it is high exactly while in PLAY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_play_reset_n <= 1'b0;
        end else begin
            r_play_reset_n <= (w_state_next == ST_PLAY);
        end
    end

    // Completed-play counter: cleared on an accepted start, wraps freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plays <= '0;
        end else if (w_start_accept) begin
            r_plays <= '0;
        end else if (w_done_evt) begin
            r_plays <= w_plays_inc;
        end
    end

    // Gap down-counter, loaded from the live GAP value at each done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (w_done_evt && !w_complete) begin
            r_gap_cnt <= w_gap_load;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt - COUNT_BITS'(1);
        end
    end

    // Software-programmed configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_repeat     <= '0;
            r_gap        <= '0;
            r_irq_enable <= 1'b0;
        end else begin
            if (w_wr_repeat) begin
                r_repeat <= bus.csr_writedata[COUNT_BITS-1:0];
            end
            if (w_wr_gap) begin
                r_gap <= bus.csr_writedata[COUNT_BITS-1:0];
            end
            if (w_wr_control) begin
                r_irq_enable <= bus.csr_writedata[2];
            end
        end
    end

    // Completion flag: a completion in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_pending <= 1'b0;
        end else if (w_complete) begin
            r_irq_pending <= 1'b1;
        end else if (w_wr_plays) begin
            r_irq_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // CSR read path
    // ------------------------------------------------------------------
    assign w_control_rd = {27'd0, r_state, r_irq_enable, r_irq_pending, w_busy};

    // Read data is captured from pre-write register values and held
    // between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csr_readdata <= 32'd0;
        end else if (bus.csr_read) begin
            case (bus.csr_address)
                C_ADDR_CONTROL: r_csr_readdata <= w_control_rd;
                C_ADDR_REPEAT:  r_csr_readdata <= 32'(r_repeat);
                C_ADDR_GAP:     r_csr_readdata <= 32'(r_gap);
                C_ADDR_PLAYS:   r_csr_readdata <= 32'(r_plays);
                default:        r_csr_readdata <= 32'd0;
            endcase
        end
    end

    assign bus.csr_readdata = r_csr_readdata;
    assign bus.play_reset_n = r_play_reset_n;
    assign bus.irq          = r_irq_pending & r_irq_enable;

endmodule
`default_nettype wire

// File: tb/tb_player_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_sequencer
//  Description : Self-checking bench for player_sequencer. CSR read
//                expectations and inter-play gap lengths are queued by the
//                stimulus and compared by independent monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_player_sequencer;

    localparam int COUNT_BITS = 16;
    localparam int PLAY_LEN   = 10;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    rd_exp_t rd_q[$];
    int      gap_q[$];

    logic    rd_seen = 1'b0;
    rd_exp_t rd_cur;

    logic model_en;
    logic model_done = 1'b0;
    logic manual_done;
    int   hi_cnt = 0;

    logic prev_prn = 1'b0;
    logic had_high = 1'b0;
    logic run_new  = 1'b0;
    int   low_cnt  = 0;
    int   windows  = 0;
    int   gap_exp;

    player_sequencer_if bus ();

    player_sequencer #(.COUNT_BITS(COUNT_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.play_done = model_en ? model_done : manual_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read-data monitor: a read accepted at a rising edge is compared at
    // the following falling edge against the oldest queued expectation.
    always @(posedge clk) rd_seen = bus.csr_read;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rd_cur = rd_q.pop_front();
                check(rd_cur.name, bus.csr_readdata, rd_cur.exp);
            end
        end
    end

    // Player model: done on the PLAY_LEN-th cycle of each high window.
    always @(negedge clk) begin
        if (!bus.play_reset_n) begin
            hi_cnt     = 0;
            model_done = 1'b0;
        end else begin
            hi_cnt++;
            model_done = (hi_cnt == PLAY_LEN);
        end
    end

    // Window monitor: counts high windows and measures the low run before
    // each re-raise inside a run.
    always @(negedge clk) begin
        if (bus.play_reset_n) begin
            if (!prev_prn) begin
                if (had_high && !run_new) begin
                    if (gap_q.size() == 0) begin
                        check("gap_unexpected", 32'(low_cnt), 32'd0);
                    end else begin
                        gap_exp = gap_q.pop_front();
                        check("gap_len", 32'(low_cnt), 32'(gap_exp));
                    end
                end
                had_high = 1'b1;
                run_new  = 1'b0;
            end
        end else begin
            if (prev_prn) begin
                windows++;
                low_cnt = 0;
            end
            low_cnt++;
        end
        prev_prn = bus.play_reset_n;
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.csr_address   = a;
        bus.csr_writedata = d;
        bus.csr_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(negedge clk);
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        bus.csr_address = a;
        bus.csr_read    = 1'b1;
        @(posedge clk);
        #1;
        bus.csr_read = 1'b0;
    endtask

    task automatic wait_falls(input int target, input int budget, input string name);
        int n = 0;
        while (windows < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (windows >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_high(input int budget, input string name);
        int n = 0;
        while (!bus.play_reset_n && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.play_reset_n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        reset             = 1'b1;
        bus.csr_address   = 2'd0;
        bus.csr_write     = 1'b0;
        bus.csr_writedata = 32'd0;
        bus.csr_read      = 1'b0;
        model_en          = 1'b1;
        manual_done       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        check("t1_play_reset_n", 32'(bus.play_reset_n), 32'd0);
        check("t1_irq", 32'(bus.irq), 32'd0);
        csr_rd(2'd0, 32'd0, "t1_control");
        csr_rd(2'd1, 32'd0, "t1_repeat");
        csr_rd(2'd2, 32'd0, "t1_gap");
        csr_rd(2'd3, 32'd0, "t1_plays");

        // 2: three plays separated by four-cycle gaps, then irq
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd2, 32'd4);
        base    = windows;
        run_new = 1'b1;
        gap_q.push_back(4);
        gap_q.push_back(4);
        csr_wr(2'd0, 32'h5);
        csr_rd(2'd0, 32'hD, "t2_control_play");
        wait_falls(base + 3, 200, "t2_three_plays");
        repeat (3) @(negedge clk);
        check("t2_windows", 32'(windows - base), 32'd3);
        check("t2_play_reset_n_idle", 32'(bus.play_reset_n), 32'd0);
        check("t2_irq_set", 32'(bus.irq), 32'd1);
        csr_rd(2'd0, 32'h6, "t2_control_done");
        csr_rd(2'd3, 32'd3, "t2_plays");
        csr_wr(2'd3, 32'd0);
        check("t2_irq_cleared", 32'(bus.irq), 32'd0);
        csr_rd(2'd0, 32'h4, "t2_control_cleared");

        // 3: GAP=0 behaves as a one-cycle gap
        csr_wr(2'd2, 32'd0);
        csr_wr(2'd1, 32'd2);
        base    = windows;
        run_new = 1'b1;
        gap_q.push_back(1);
        csr_wr(2'd0, 32'h5);
        wait_falls(base + 2, 100, "t3_two_plays");
        repeat (3) @(negedge clk);
        check("t3_windows", 32'(windows - base), 32'd2);
        csr_rd(2'd3, 32'd2, "t3_plays");
        csr_rd(2'd0, 32'h6, "t3_control_done");
        csr_wr(2'd3, 32'd0);

        // 4: loop forever, stop during the sixth play
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, 32'd2);
        base    = windows;
        run_new = 1'b1;
        for (int i = 0; i < 5; i++) gap_q.push_back(2);
        csr_wr(2'd0, 32'h5);
        wait_falls(base + 5, 300, "t4_five_plays");
        wait_high(20, "t4_sixth_play");
        csr_wr(2'd0, 32'h6);
        check("t4_stop_drop", 32'(bus.play_reset_n), 32'd0);
        check("t4_irq", 32'(bus.irq), 32'd0);
        csr_rd(2'd3, 32'd5, "t4_plays_kept");
        csr_rd(2'd0, 32'h4, "t4_control_stopped");
        repeat (12) @(negedge clk);
        check("t4_stays_idle", 32'(bus.play_reset_n), 32'd0);
        run_new = 1'b1;
        csr_wr(2'd0, 32'h5);
        csr_rd(2'd3, 32'd0, "t4_plays_cleared");
        csr_wr(2'd0, 32'h6);

        // 5: start|stop stays idle; a start while busy changes nothing
        csr_wr(2'd0, 32'h7);
        check("t5_start_stop_prn", 32'(bus.play_reset_n), 32'd0);
        csr_rd(2'd0, 32'h4, "t5_start_stop_idle");
        csr_wr(2'd1, 32'd2);
        csr_wr(2'd2, 32'd3);
        base    = windows;
        run_new = 1'b1;
        gap_q.push_back(3);
        csr_wr(2'd0, 32'h5);
        wait_falls(base + 1, 100, "t5_first_play");
        wait_high(20, "t5_second_play");
        repeat (2) @(negedge clk);
        csr_wr(2'd0, 32'h5);
        csr_rd(2'd0, 32'hD, "t5_still_play");
        wait_falls(base + 2, 100, "t5_two_plays");
        repeat (6) @(negedge clk);
        check("t5_windows", 32'(windows - base), 32'd2);
        check("t5_prn_idle", 32'(bus.play_reset_n), 32'd0);
        csr_rd(2'd3, 32'd2, "t5_plays");
        csr_rd(2'd0, 32'h6, "t5_control_done");
        csr_wr(2'd3, 32'd0);

        // 6a: asynchronous reset during GAP and during PLAY
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, 32'd20);
        run_new = 1'b1;
        base    = windows;
        csr_wr(2'd0, 32'h5);
        wait_falls(base + 1, 50, "t6_gap_reached");
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_gap_reset_prn", 32'(bus.play_reset_n), 32'd0);
        check("t6_gap_reset_readdata", bus.csr_readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        csr_rd(2'd0, 32'd0, "t6_control_reset");
        csr_rd(2'd1, 32'd0, "t6_repeat_reset");
        csr_rd(2'd2, 32'd0, "t6_gap_reset");
        csr_rd(2'd3, 32'd0, "t6_plays_reset");
        run_new = 1'b1;
        csr_wr(2'd0, 32'h1);
        wait_high(20, "t6_play_reached");
        #2;
        reset = 1'b1;
        #1;
        check("t6_play_reset_async", 32'(bus.play_reset_n), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 6b: irq clear in the completion cycle loses to the set
        model_en = 1'b0;
        csr_wr(2'd1, 32'd1);
        csr_wr(2'd2, 32'd1);
        run_new = 1'b1;
        csr_wr(2'd0, 32'h5);
        repeat (2) @(negedge clk);
        @(negedge clk);
        manual_done       = 1'b1;
        bus.csr_address   = 2'd3;
        bus.csr_writedata = 32'd0;
        bus.csr_write     = 1'b1;
        @(posedge clk);
        #1;
        manual_done   = 1'b0;
        bus.csr_write = 1'b0;
        check("t6_set_wins_irq", 32'(bus.irq), 32'd1);
        csr_rd(2'd0, 32'h6, "t6_set_wins_control");
        csr_rd(2'd3, 32'd1, "t6_plays_one");
        @(negedge clk);
        manual_done = 1'b1;
        @(posedge clk);
        #1;
        manual_done = 1'b0;
        csr_rd(2'd3, 32'd1, "t6_idle_done_ignored");
        csr_wr(2'd3, 32'd0);
        check("t6_irq_cleared", 32'(bus.irq), 32'd0);
        model_en = 1'b1;

        repeat (3) @(negedge clk);
        check("gap_queue_drained", 32'(gap_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
